// File: rtl/ex_mem_stage.sv
// ---------------------------------------------------------------------------
// ex_mem_stage
//   EX -> MEM pipeline boundary. EX result bundles are held in a two-entry
//   skid buffer (head + skid) with valid/ready handshakes on both sides.
//   The head entry drives the MEM/dcache bundle. An accepted taken branch
//   raises a one-cycle fetch redirect. Beats accepted while that redirect is
//   showing are wrong-path and are swallowed without reaching MEM.
//
//   Optional feature macro: EXMEM_MISALIGN_CHECK_EN
//     defined   : a misalignment flag is computed when a beat is accepted,
//                 stored with the entry and shown on mem_misalign.
//     undefined : mem_misalign is tied low and no check logic exists.
// ---------------------------------------------------------------------------
module ex_mem_stage #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int RD_W   = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    // EX side
    input  logic              ex_valid,
    output logic              ex_ready,
    input  logic [DATA_W-1:0] EX_AluData,
    input  logic [ADDR_W-1:0] EX_BranchPC,
    input  logic              EX_BranchFlag,
    input  logic              EX_LdStFlag,
    input  logic [2:0]        IDEX_LdType,
    input  logic [1:0]        IDEX_StType,
    input  logic [DATA_W-1:0] ex_stdata,
    input  logic [RD_W-1:0]   ex_rd,
    // MEM side
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic [DATA_W-1:0] mem_aludata,
    output logic [DATA_W-1:0] mem_stdata,
    output logic [RD_W-1:0]   mem_rd,
    output logic [2:0]        mem_ldtype,
    output logic [1:0]        mem_sttype,
    output logic              mem_ldst,
    // fetch redirect
    output logic              br_redirect,
    output logic [ADDR_W-1:0] br_target,
    // alignment flag for the head bundle
    output logic              mem_misalign
);

    // One buffer entry. The misalign bit only exists when the check is built.
    typedef struct packed {
        logic [DATA_W-1:0] alu;
        logic [DATA_W-1:0] stdata;
        logic [RD_W-1:0]   rd;
        logic [2:0]        ldtype;
        logic [1:0]        sttype;
        logic              ldst;
`ifdef EXMEM_MISALIGN_CHECK_EN
        logic              mis;
`endif
    } bundle_t;

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_FULL  = 2'd2
    } state_t;

`ifdef EXMEM_MISALIGN_CHECK_EN
    // Halfword accesses need addr[0]==0, word accesses need addr[1:0]==0.
    // Load type 2/5 = LH/LHU, 3 = LW; store type 2 = SH, 3 = SW.
    function automatic logic misaligned(input logic       ldst,
                                        input logic [2:0] ldtype,
                                        input logic [1:0] sttype,
                                        input logic [1:0] addr_lo);
        logic half_acc;
        logic word_acc;
        half_acc = (ldtype == 3'd2) || (ldtype == 3'd5) || (sttype == 2'd2);
        word_acc = (ldtype == 3'd3) || (sttype == 2'd3);
        return ldst && ((half_acc && addr_lo[0]) ||
                        (word_acc && (addr_lo != 2'b00)));
    endfunction
`endif

    state_t            state_p1;
    state_t            state_nxt;
    logic              ex_ready_p1;
    logic              vld_p1;
    logic              br_redirect_p1;
    logic [ADDR_W-1:0] br_target_p1;
    bundle_t           in_p0;
    bundle_t           head_p1;
    bundle_t           skid_p1;

    logic              accept;
    logic              load;
    logic              retire;
    logic              head_from_in;
    logic              head_from_skid;
    logic              skid_from_in;

    // ---- stage p0: incoming EX bundle -------------------------------------
    always_comb begin
        in_p0        = '0;
        in_p0.alu    = EX_AluData;
        in_p0.stdata = ex_stdata;
        in_p0.rd     = ex_rd;
        in_p0.ldtype = IDEX_LdType;
        in_p0.sttype = IDEX_StType;
        in_p0.ldst   = EX_LdStFlag;
`ifdef EXMEM_MISALIGN_CHECK_EN
        in_p0.mis    = misaligned(EX_LdStFlag, IDEX_LdType, IDEX_StType,
                                  EX_AluData[1:0]);
`endif
    end

    // A beat is consumed whenever valid meets ready, but it only enters the
    // buffer if it is neither flushed nor on the wrong path of a redirect.
    assign accept = ex_valid && ex_ready_p1;
    assign load   = accept && !flush && !br_redirect_p1;
    assign vld_p1 = (state_p1 != S_EMPTY);
    assign retire = vld_p1 && mem_ready;

    // ---- stage p1: buffer state and entries -------------------------------
    // State register; ex_ready is registered from the next state so it has
    // no combinational path from mem_ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_p1    <= S_EMPTY;
            ex_ready_p1 <= 1'b1;
        end else begin
            state_p1    <= state_nxt;
            ex_ready_p1 <= (state_nxt != S_FULL);
        end
    end

    // Next-state logic; flush overrides every simultaneous transfer.
    always_comb begin
        state_nxt = state_p1;
        if (flush) begin
            state_nxt = S_EMPTY;
        end else begin
            case (state_p1)
                S_EMPTY: if (load) state_nxt = S_ONE;
                S_ONE: begin
                    if (load && !retire)      state_nxt = S_FULL;
                    else if (!load && retire) state_nxt = S_EMPTY;
                end
                S_FULL:  if (retire) state_nxt = S_ONE;
                default: state_nxt = S_EMPTY;
            endcase
        end
    end

    // Entry-move controls derived from the current state and transfers.
    always_comb begin
        head_from_in   = 1'b0;
        head_from_skid = 1'b0;
        skid_from_in   = 1'b0;
        if (!flush) begin
            case (state_p1)
                S_EMPTY: head_from_in = load;
                S_ONE: begin
                    head_from_in = load && retire;
                    skid_from_in = load && !retire;
                end
                S_FULL:  head_from_skid = retire;
                default: ;
            endcase
        end
    end

    // Head entry: only rewritten when empty or while retiring, so a bundle
    // stalled by MEM stays stable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_p1 <= '0;
        end else if (head_from_in) begin
            head_p1 <= in_p0;
        end else if (head_from_skid) begin
            head_p1 <= skid_p1;
        end
    end

    // Skid entry catches the beat that arrives while the head is stalled.
    always_ff @(posedge clk) begin
        if (skid_from_in) begin
            skid_p1 <= in_p0;
        end
    end

    // One-cycle redirect for a taken branch that actually enters the buffer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            br_redirect_p1 <= 1'b0;
            br_target_p1   <= '0;
        end else begin
            br_redirect_p1 <= load && EX_BranchFlag;
            if (load && EX_BranchFlag) begin
                br_target_p1 <= EX_BranchPC;
            end
        end
    end

    assign ex_ready    = ex_ready_p1;
    assign mem_valid   = vld_p1;
    assign mem_aludata = head_p1.alu;
    assign mem_stdata  = head_p1.stdata;
    assign mem_rd      = head_p1.rd;
    assign mem_ldtype  = head_p1.ldtype;
    assign mem_sttype  = head_p1.sttype;
    assign mem_ldst    = head_p1.ldst;
    assign br_redirect = br_redirect_p1;
    assign br_target   = br_target_p1;

`ifdef EXMEM_MISALIGN_CHECK_EN
    assign mem_misalign = vld_p1 && head_p1.mis;
`else
    assign mem_misalign = 1'b0;
`endif

endmodule

// File: tb/tb_ex_mem_stage.sv
// ---------------------------------------------------------------------------
// tb_ex_mem_stage
//   Directed bench for ex_mem_stage: reset, streaming, backpressure, branch
//   redirect with wrong-path drop, flush, and the alignment flag
//   (EXMEM_MISALIGN_CHECK_EN selects the expected flag values).
// ---------------------------------------------------------------------------
module tb_ex_mem_stage;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;
    localparam int RD_W   = 5;

`ifdef EXMEM_MISALIGN_CHECK_EN
    localparam logic MIS_ON = 1'b1;
`else
    localparam logic MIS_ON = 1'b0;
`endif

    logic              clk;
    logic              rst_n;
    logic              flush;
    logic              ex_valid;
    logic              ex_ready;
    logic [DATA_W-1:0] EX_AluData;
    logic [ADDR_W-1:0] EX_BranchPC;
    logic              EX_BranchFlag;
    logic              EX_LdStFlag;
    logic [2:0]        IDEX_LdType;
    logic [1:0]        IDEX_StType;
    logic [DATA_W-1:0] ex_stdata;
    logic [RD_W-1:0]   ex_rd;
    logic              mem_valid;
    logic              mem_ready;
    logic [DATA_W-1:0] mem_aludata;
    logic [DATA_W-1:0] mem_stdata;
    logic [RD_W-1:0]   mem_rd;
    logic [2:0]        mem_ldtype;
    logic [1:0]        mem_sttype;
    logic              mem_ldst;
    logic              br_redirect;
    logic [ADDR_W-1:0] br_target;
    logic              mem_misalign;

    int n_chk  = 0;
    int n_fail = 0;

    logic [31:0] retired[$];
    logic [31:0] expq[$];

    ex_mem_stage #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W),
        .RD_W  (RD_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .ex_valid     (ex_valid),
        .ex_ready     (ex_ready),
        .EX_AluData   (EX_AluData),
        .EX_BranchPC  (EX_BranchPC),
        .EX_BranchFlag(EX_BranchFlag),
        .EX_LdStFlag  (EX_LdStFlag),
        .IDEX_LdType  (IDEX_LdType),
        .IDEX_StType  (IDEX_StType),
        .ex_stdata    (ex_stdata),
        .ex_rd        (ex_rd),
        .mem_valid    (mem_valid),
        .mem_ready    (mem_ready),
        .mem_aludata  (mem_aludata),
        .mem_stdata   (mem_stdata),
        .mem_rd       (mem_rd),
        .mem_ldtype   (mem_ldtype),
        .mem_sttype   (mem_sttype),
        .mem_ldst     (mem_ldst),
        .br_redirect  (br_redirect),
        .br_target    (br_target),
        .mem_misalign (mem_misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every bundle MEM takes; inputs are stable at the falling edge.
    always @(negedge clk) begin
        if (rst_n && !flush && mem_valid && mem_ready) begin
            retired.push_back(mem_aludata);
        end
    end

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Compare the retired stream against expq, then clear both.
    task automatic chk_stream(input string tag);
        chk({tag, "_count"}, 64'(retired.size()), 64'(expq.size()));
        for (int i = 0; i < expq.size(); i++) begin
            if (i < retired.size()) begin
                chk($sformatf("%s_beat%0d", tag, i), 64'(retired[i]), 64'(expq[i]));
            end
        end
        retired.delete();
        expq.delete();
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] alu,
                         input logic br, input logic [31:0] pc,
                         input logic ldst, input logic [2:0] ld,
                         input logic [1:0] st);
        ex_valid      = v;
        EX_AluData    = alu;
        EX_BranchFlag = br;
        EX_BranchPC   = pc;
        EX_LdStFlag   = ldst;
        IDEX_LdType   = ld;
        IDEX_StType   = st;
        ex_stdata     = alu ^ 32'hFFFF_0000;
        ex_rd         = alu[4:0];
    endtask

    task automatic idle();
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 3'd0, 2'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        mem_ready = 1'b0;
        idle();

        // Reset state
        repeat (3) cyc();
        chk("rst_mem_valid", 64'(mem_valid), 64'd0);
        chk("rst_ex_ready", 64'(ex_ready), 64'd1);
        chk("rst_br_redirect", 64'(br_redirect), 64'd0);
        chk("rst_aludata", 64'(mem_aludata), 64'd0);
        chk("rst_misalign", 64'(mem_misalign), 64'd0);
        rst_n = 1'b1;
        cyc();

        // Streaming with MEM always ready: one-cycle latency, ready stays high
        mem_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'((i + 1) * 16), 1'b0, 32'h0, 1'b0, 3'd0, 2'd0);
            cyc();
            chk($sformatf("stream_valid%0d", i), 64'(mem_valid), 64'd1);
            chk($sformatf("stream_alu%0d", i), 64'(mem_aludata), 64'((i + 1) * 16));
            chk($sformatf("stream_ready%0d", i), 64'(ex_ready), 64'd1);
        end
        idle();
        cyc();
        chk("stream_drained", 64'(mem_valid), 64'd0);
        expq = '{32'h10, 32'h20, 32'h30, 32'h40};
        chk_stream("stream");

        // Backpressure: three stalled cycles with EX pushing
        mem_ready = 1'b0;
        drive(1'b1, 32'h100, 1'b0, 32'h0, 1'b0, 3'd0, 2'd0);
        cyc();
        chk("bp_one_ready", 64'(ex_ready), 64'd1);
        chk("bp_one_alu", 64'(mem_aludata), 64'h100);
        drive(1'b1, 32'h200, 1'b0, 32'h0, 1'b0, 3'd0, 2'd0);
        cyc();
        chk("bp_full_ready", 64'(ex_ready), 64'd0);
        chk("bp_full_alu", 64'(mem_aludata), 64'h100);
        drive(1'b1, 32'h300, 1'b0, 32'h0, 1'b0, 3'd0, 2'd0);
        cyc();
        chk("bp_hold_ready", 64'(ex_ready), 64'd0);
        chk("bp_hold_alu", 64'(mem_aludata), 64'h100);
        chk("bp_hold_valid", 64'(mem_valid), 64'd1);
        mem_ready = 1'b1;
        cyc();
        chk("bp_skid_alu", 64'(mem_aludata), 64'h200);
        chk("bp_skid_ready", 64'(ex_ready), 64'd1);
        cyc();
        chk("bp_last_alu", 64'(mem_aludata), 64'h300);
        idle();
        cyc();
        chk("bp_drained", 64'(mem_valid), 64'd0);
        expq = '{32'h100, 32'h200, 32'h300};
        chk_stream("bp");

        // Branch redirect and wrong-path drop
        drive(1'b1, 32'h44, 1'b1, 32'h8000_0100, 1'b0, 3'd0, 2'd0);
        cyc();
        chk("br_redirect_on", 64'(br_redirect), 64'd1);
        chk("br_target", 64'(br_target), 64'h8000_0100);
        chk("br_bundle_valid", 64'(mem_valid), 64'd1);
        chk("br_bundle_alu", 64'(mem_aludata), 64'h44);
        drive(1'b1, 32'hDEAD, 1'b0, 32'h0, 1'b0, 3'd0, 2'd0);
        cyc();
        chk("br_redirect_off", 64'(br_redirect), 64'd0);
        chk("br_wrongpath_valid", 64'(mem_valid), 64'd0);
        chk("br_wrongpath_ready", 64'(ex_ready), 64'd1);
        drive(1'b1, 32'h55, 1'b0, 32'h0, 1'b0, 3'd0, 2'd0);
        cyc();
        chk("br_next_alu", 64'(mem_aludata), 64'h55);
        idle();
        cyc();
        expq = '{32'h44, 32'h55};
        chk_stream("br");

        // Flush from FULL with EX still pushing
        mem_ready = 1'b0;
        drive(1'b1, 32'hA1, 1'b0, 32'h0, 1'b0, 3'd0, 2'd0);
        cyc();
        drive(1'b1, 32'hA2, 1'b0, 32'h0, 1'b0, 3'd0, 2'd0);
        cyc();
        chk("fl_full_ready", 64'(ex_ready), 64'd0);
        drive(1'b1, 32'hA3, 1'b0, 32'h0, 1'b0, 3'd0, 2'd0);
        flush = 1'b1;
        cyc();
        chk("fl_valid", 64'(mem_valid), 64'd0);
        chk("fl_ready", 64'(ex_ready), 64'd1);
        drive(1'b1, 32'hA4, 1'b1, 32'h200, 1'b0, 3'd0, 2'd0);
        cyc();
        chk("fl_same_cycle_valid", 64'(mem_valid), 64'd0);
        chk("fl_same_cycle_redirect", 64'(br_redirect), 64'd0);
        flush     = 1'b0;
        mem_ready = 1'b1;
        idle();
        repeat (2) cyc();
        chk("fl_after_valid", 64'(mem_valid), 64'd0);
        chk_stream("fl");

        // Alignment flag
        drive(1'b1, 32'h1002, 1'b0, 32'h0, 1'b1, 3'd3, 2'd0);
        cyc();
        chk("mis_lw_1002", 64'(mem_misalign), 64'(MIS_ON));
        chk("mis_lw_ldtype", 64'(mem_ldtype), 64'd3);
        chk("mis_lw_ldst", 64'(mem_ldst), 64'd1);
        chk("mis_lw_stdata", 64'(mem_stdata), 64'hFFFF_1002);
        chk("mis_lw_rd", 64'(mem_rd), 64'd2);
        drive(1'b1, 32'h1002, 1'b0, 32'h0, 1'b1, 3'd2, 2'd0);
        cyc();
        chk("mis_lh_1002", 64'(mem_misalign), 64'd0);
        drive(1'b1, 32'h1001, 1'b0, 32'h0, 1'b1, 3'd0, 2'd2);
        cyc();
        chk("mis_sh_1001", 64'(mem_misalign), 64'(MIS_ON));
        chk("mis_sh_sttype", 64'(mem_sttype), 64'd2);
        drive(1'b1, 32'h1001, 1'b0, 32'h0, 1'b0, 3'd0, 2'd0);
        cyc();
        chk("mis_noldst", 64'(mem_misalign), 64'd0);
        idle();
        cyc();
        chk("mis_idle", 64'(mem_misalign), 64'd0);
        retired.delete();

        // Asynchronous reset while FULL with a redirect showing
        mem_ready = 1'b0;
        drive(1'b1, 32'h71, 1'b0, 32'h0, 1'b0, 3'd0, 2'd0);
        cyc();
        drive(1'b1, 32'h72, 1'b1, 32'h123, 1'b0, 3'd0, 2'd0);
        cyc();
        chk("ar_pre_ready", 64'(ex_ready), 64'd0);
        chk("ar_pre_redirect", 64'(br_redirect), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("ar_valid", 64'(mem_valid), 64'd0);
        chk("ar_redirect", 64'(br_redirect), 64'd0);
        chk("ar_ready", 64'(ex_ready), 64'd1);
        chk("ar_aludata", 64'(mem_aludata), 64'd0);
        chk("ar_target", 64'(br_target), 64'd0);
        idle();
        #2;
        rst_n = 1'b1;
        cyc();
        chk("ar_after_valid", 64'(mem_valid), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
